// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative multiply/divide sequencer owning the HI/LO pair
// Optional: define MDU_EARLY_OUT_EN to let mult/multu leave CALC once the
// remaining multiplier bits are all zero (divide timing is unaffected).
module mdu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mf_req,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   count_q;
   logic               is_div_q;
   logic               neg_res_q;   // product / quotient must be negated
   logic               neg_rem_q;   // remainder takes the dividend's sign
   logic               dz_q;        // divide with a zero divisor
   // Multiply: opa_q = multiplicand shifted left each step, opb_q = multiplier
   // shifted right, acc_q = running product (one spare bit above 2*WIDTH).
   // Divide: opa_q[WIDTH-1:0] = divisor, opb_q = dividend shifting out while
   // quotient bits shift in, acc_q[WIDTH:0] = partial remainder.
   logic [2*WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q, dz_pulse_q;

   logic               op_signed, op_is_mul, op_is_div;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH:0]   mul_sum;
   logic [WIDTH:0]     r_shift, diff;
   logic               last_iter, early_exit;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   rem, rem_neg, quot, quot_neg;

   // Operand decode and magnitude conversion for the latch in IDLE
   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
      op_is_div = (op == OP_DIV) || (op == OP_DIVU);
      a_neg     = op_signed & src_a[WIDTH-1];
      b_neg     = op_signed & src_b[WIDTH-1];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
   end

   // One shift-add or restoring shift-subtract iteration
   always_comb begin
      mul_sum = acc_q + (opb_q[0] ? {1'b0, opa_q} : '0);
      r_shift = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
      diff    = r_shift - {1'b0, opa_q[WIDTH-1:0]};
      if (is_div_q) begin
         acc_d = {{WIDTH{1'b0}}, (diff[WIDTH] ? r_shift : diff)};
         opb_d = {opb_q[WIDTH-2:0], ~diff[WIDTH]};
         opa_d = opa_q;
      end else begin
         acc_d = mul_sum;
         opb_d = {1'b0, opb_q[WIDTH-1:1]};
         opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
      end
   end

   assign last_iter = (count_q == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
   // Nothing left to add once the unconsumed multiplier bits are zero
   assign early_exit = !is_div_q && (opb_q[WIDTH-1:1] == '0);
`else
   assign early_exit = 1'b0;
`endif

   // Sign fix-up candidates for the SIGN state
   always_comb begin
      prod     = acc_q[2*WIDTH-1:0];
      prod_neg = -prod;
      rem      = acc_q[WIDTH-1:0];
      rem_neg  = -rem;
      quot     = opb_q;
      quot_neg = -quot;
   end

   // Sequencer FSM with registered HI/LO and done/div_zero pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !flush) begin
                  if (op_is_mul || op_is_div) begin
                     state_q   <= S_CALC;
                     count_q   <= '0;
                     is_div_q  <= op_is_div;
                     neg_res_q <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                     dz_q      <= op_is_div && (src_b == '0);
                     acc_q     <= '0;
                     if (op_is_div) begin
                        opa_q <= {{WIDTH{1'b0}}, b_mag};
                        opb_q <= a_mag;
                     end else begin
                        opa_q <= {{WIDTH{1'b0}}, a_mag};
                        opb_q <= b_mag;
                     end
                  end else if (op == OP_MTHI) begin
                     hi_q <= src_a;
                  end else if (op == OP_MTLO) begin
                     lo_q <= src_a;
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else begin
                  acc_q   <= acc_d;
                  opa_q   <= opa_d;
                  opb_q   <= opb_d;
                  count_q <= count_q + CNT_W'(1);
                  if (last_iter || early_exit) begin
                     state_q <= S_SIGN;
                  end
               end
            end
            S_SIGN: begin
               state_q <= S_IDLE;
               if (!flush) begin
                  done_q <= 1'b1;
                  if (is_div_q) begin
                     // With a zero divisor every step subtracts nothing, so the
                     // remainder register ends up holding |dividend|; restoring
                     // the dividend's sign gives back src_a unchanged.
                     hi_q <= neg_rem_q ? rem_neg : rem;
                     if (dz_q) begin
                        lo_q       <= '1;
                        dz_pulse_q <= 1'b1;
                     end else begin
                        lo_q <= neg_res_q ? quot_neg : quot;
                     end
                  end else begin
                     hi_q <= neg_res_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
                     lo_q <= neg_res_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign stall    = busy & (start | mf_req);
   assign done     = done_q;
   assign div_zero = dz_pulse_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
